apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
//  Shares the apb_if master side (paddr/prwd/pwdata/penable/psel) among NUM_REQ requesters.
//  - Round-robin arbitration; sequences the APB SETUP -> ACCESS phases.
//  - Decodes psel one-hot from the address; honours pready wait states.
//  - Returns prdata/pslverr to the granted requester.
// PARAMETERS
//  NUM_REQ        2   number of requesters (2..8)
//  PADDR_WIDTH    32  APB address width
//  PWDATA_WIDTH   8   APB write/read data width (PRDATA_WIDTH equals PWDATA_WIDTH)
//  SEL_LSB        12  paddr[SEL_LSB+3:SEL_LSB] selects psel bit (16 slaves)
//  TIMEOUT_CYCLES 16  ACCESS wait limit; used only with APB_ARB_TIMEOUT_EN
// PORTS
//  pclock     in   1                     APB clock; all logic on its rising edge
//  preset     in   1                     asynchronous, active-low reset
//  req        in   NUM_REQ               per-requester transfer request, held until done
//  req_addr   in   NUM_REQ*PADDR_WIDTH   packed address; requester i at [i*PADDR_WIDTH +: PADDR_WIDTH]
//  req_write  in   NUM_REQ               1 = write, 0 = read
//  req_wdata  in   NUM_REQ*PWDATA_WIDTH  packed write data
//  done       out  NUM_REQ               one-cycle completion pulse to requester i
//  rsp_rdata  out  PWDATA_WIDTH          read data; valid while done is high
//  rsp_err    out  1                     pslverr (or timeout); valid while done is high
//  busy       out  1                     high in SETUP or ACCESS
//  paddr      out  PADDR_WIDTH           APB address
//  prwd       out  1                     APB direction, 1 = write
//  pwdata     out  PWDATA_WIDTH          APB write data
//  penable    out  1                     APB enable
//  psel       out  16                    APB one-hot slave select
//  prdata     in   PWDATA_WIDTH          APB read data
//  pready     in   1                     APB slave ready
//  pslverr    in   1                     APB slave error
// BEHAVIOUR
//  - Reset (preset=0, asynchronous): state IDLE, round-robin pointer 0.
//    All outputs 0: paddr, prwd, pwdata, penable, psel, done, rsp_rdata, rsp_err, busy.
//  - Reset mid-transfer aborts the transfer immediately; no done pulse is issued.
//  - FSM IDLE:
//    - Any req high -> grant the first requester at or after the pointer (wrapping modulo NUM_REQ).
//    - Register paddr/prwd/pwdata from the winner; psel = 1 << paddr[SEL_LSB+3:SEL_LSB].
//    - Go to SETUP.
//  - FSM SETUP (one cycle): psel one-hot, penable=0, busy=1; next state ACCESS.
//  - FSM ACCESS: penable=1; paddr/prwd/pwdata/psel held stable.
//    - While pready=0: stay in ACCESS (wait state).
//    - On pready=1:
//      - done[g] pulses for 1 cycle (the following cycle).
//      - rsp_rdata <= prdata for reads; rsp_rdata holds its previous value for writes.
//      - rsp_err <= pslverr.
//      - pointer <= g+1 (wraps to 0 after NUM_REQ-1).
//  - Back-to-back: in the ACCESS completion cycle, arbitrate over the other pending requests.
//    - req[g] is masked in that cycle.
//    - If any other request is pending -> SETUP directly (penable=0, new psel/paddr); no IDLE cycle.
//    - Otherwise -> IDLE; psel=0, penable=0.
//  - Requester protocol: deassert req, or present a new request, in the cycle after done.
//    Changes to req_* while granted are ignored because fields are latched in IDLE/arbitration.
//  - Latency, single idle request: req at cycle 0 -> SETUP at 1, ACCESS at 2.
//    pready=1 at 2 -> done at 3. Each wait state adds 1 cycle.
//  - Simultaneous requests: the pointer decides; equal long-run share, no starvation.
//  - Only one psel bit is ever high; psel=0 in IDLE.
// CONFIGURATION
//  APB_ARB_TIMEOUT_EN defined:
//    - A counter runs in ACCESS.
//    - If pready is still 0 after TIMEOUT_CYCLES ACCESS cycles, the transfer terminates as if pready=1.
//    - rsp_err=1 and rsp_rdata=0; the FSM proceeds as on normal completion.
//  APB_ARB_TIMEOUT_EN undefined:
//    - No counter; ACCESS waits indefinitely for pready.
// TESTING
//  1 Single write: req[0], addr 0x0000_3004, wdata 0xA5, pready=1 at first ACCESS.
//    -> psel=16'h0008, prwd=1, penable high exactly 1 cycle, done[0] 3 cycles after req, rsp_err=0.
//  2 Read with 3 wait states: req[1] read, addr 0x0000_1000, pready after 3 cycles, prdata=0x5C, pslverr=1.
//    -> done[1] at cycle 6, rsp_rdata=0x5C, rsp_err=1, paddr stable throughout.
//  3 Contention: req[0] and req[1] held high for 4 transfers.
//    -> grants 0,1,0,1; SETUP follows ACCESS with no IDLE cycle; psel never 0 between them.
//  4 Reset mid-ACCESS: preset low during a wait state.
//    -> psel/penable/busy go to 0 that cycle; no done pulse; after release, requester 0 is granted first.
//  5 Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): pready held 0.
//    -> done after 16 ACCESS cycles with rsp_err=1, rsp_rdata=0.
//    Without the macro, busy stays 1 for 100 cycles with no done.
//  6 Decode sweep: addresses with paddr[15:12]=0..15.
//    -> psel equals 1<<n each time and $onehot(psel) holds whenever busy.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master arbiter: NUM_REQ requesters share one APB SETUP/ACCESS sequencer.
// Optional ACCESS watchdog is enabled with `define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int PADDR_WIDTH    = 32,
  parameter int PWDATA_WIDTH   = 8,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            pclock,
  input  logic                            preset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*PADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*PWDATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]              done,
  output logic [PWDATA_WIDTH-1:0]         rsp_rdata,
  output logic                            rsp_err,
  output logic                            busy,
  output logic [PADDR_WIDTH-1:0]          paddr,
  output logic                            prwd,
  output logic [PWDATA_WIDTH-1:0]         pwdata,
  output logic                            penable,
  output logic [15:0]                     psel,
  input  logic [PWDATA_WIDTH-1:0]         prdata,
  input  logic                            pready,
  input  logic                            pslverr
);
  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || SEL_LSB + 4 > PADDR_WIDTH) begin : g_bad_params
    $error("apb_master_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;
  state_t r_state, w_next;

  logic [PW-1:0]           r_ptr, r_gnt, w_win, w_base, w_gnt_inc;
  logic [NUM_REQ-1:0]      w_mreq, r_done;
  logic                    w_found, w_complete, w_tmo, w_load;
  logic [PADDR_WIDTH-1:0]  w_addr, r_paddr;
  logic                    w_write, r_prwd, r_err;
  logic [PWDATA_WIDTH-1:0] w_wdata, r_pwdata, r_rdata;
  logic [15:0]             r_psel;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  // r_cnt = number of ACCESS cycles already elapsed for the current transfer
  always_ff @(posedge pclock or negedge preset)
    if (!preset)                 r_cnt <= '0;
    else if (r_state == S_ACCESS) r_cnt <= r_cnt + 1'b1;
    else                         r_cnt <= '0;
  assign w_tmo = (r_state == S_ACCESS) && !pready && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  assign w_complete = (r_state == S_ACCESS) && (pready || w_tmo);
  assign w_gnt_inc  = (r_gnt == PW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
  // On completion the next search starts after the current grant, which is excluded
  assign w_base     = w_complete ? w_gnt_inc : r_ptr;

  always_comb begin
    w_mreq = req;
    if (w_complete) w_mreq[r_gnt] = 1'b0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!w_found && w_mreq[i] && PW'(i) >= w_base) begin
        w_found = 1'b1;
        w_win   = PW'(i);
      end
    for (int i = 0; i < NUM_REQ; i++)
      if (!w_found && w_mreq[i]) begin
        w_found = 1'b1;
        w_win   = PW'(i);
      end
    w_addr  = '0;
    w_write = 1'b0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (PW'(i) == w_win) begin
        w_addr  = req_addr[i*PADDR_WIDTH +: PADDR_WIDTH];
        w_write = req_write[i];
        w_wdata = req_wdata[i*PWDATA_WIDTH +: PWDATA_WIDTH];
      end
  end

  assign w_load = w_found && ((r_state == S_IDLE) || w_complete);

  always_ff @(posedge pclock or negedge preset)
    if (!preset) r_state <= S_IDLE;
    else         r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_complete) w_next = w_found ? S_SETUP : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclock or negedge preset)
    if (!preset) begin
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_paddr  <= '0;
      r_prwd   <= 1'b0;
      r_pwdata <= '0;
      r_psel   <= '0;
    end else begin
      r_done <= '0;
      if (w_complete) begin
        r_done[r_gnt] <= 1'b1;
        r_ptr         <= w_gnt_inc;
        if (w_tmo) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end else begin
          if (!r_prwd) r_rdata <= prdata;
          r_err <= pslverr;
        end
      end
      if (w_load) begin
        r_gnt    <= w_win;
        r_paddr  <= w_addr;
        r_prwd   <= w_write;
        r_pwdata <= w_wdata;
        r_psel   <= 16'h1 << w_addr[SEL_LSB +: 4];
      end else if (w_complete) begin
        r_psel <= '0;
      end
    end

  assign done      = r_done;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign busy      = (r_state != S_IDLE);
  assign penable   = (r_state == S_ACCESS);
  assign paddr     = r_paddr;
  assign prwd      = r_prwd;
  assign pwdata    = r_pwdata;
  assign psel      = r_psel;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_apb_master_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 8;

  logic            pclock = 1'b0;
  logic            preset = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err, busy;
  logic [AW-1:0]   paddr;
  logic            prwd;
  logic [DW-1:0]   pwdata;
  logic            penable;
  logic [15:0]     psel;
  logic [DW-1:0]   prdata = '0;
  logic            pready = 1'b0;
  logic            pslverr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_arbiter #(.NUM_REQ(N), .PADDR_WIDTH(AW), .PWDATA_WIDTH(DW), .SEL_LSB(12), .TIMEOUT_CYCLES(16)) dut (
    .pclock(pclock), .preset(preset), .req(req), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .prwd(prwd), .pwdata(pwdata), .penable(penable), .psel(psel),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial forever #5 pclock = ~pclock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge pclock);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    req_addr[i*AW +: AW]  = a;
    req_write[i]          = w;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    preset = 1'b0;
    tick(); tick();
    n_tests++;
    if ({paddr, prwd, pwdata, penable, psel, done, rsp_rdata, rsp_err, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: paddr=%h prwd=%b pwdata=%h pen=%b psel=%h done=%b rd=%h err=%b busy=%b, all must be 0",
               paddr, prwd, pwdata, penable, psel, done, rsp_rdata, rsp_err, busy);
    end
    preset = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    set_req(0, 32'h0000_3004, 1'b1, 8'hA5);
    req = 3'b001; pready = 1'b1; pslverr = 1'b0;
    tick();
    n_tests++;
    if ({busy, penable, psel, prwd, paddr, pwdata} !== {1'b1, 1'b0, 16'h0008, 1'b1, 32'h0000_3004, 8'hA5}) begin
      n_fail++;
      $display("FAIL write_setup: busy=%b pen=%b psel=%h prwd=%b paddr=%h pwdata=%h, want 1 0 0008 1 00003004 a5",
               busy, penable, psel, prwd, paddr, pwdata);
    end
    tick();
    n_tests++;
    if ({penable, psel, done} !== {1'b1, 16'h0008, 3'b000}) begin
      n_fail++;
      $display("FAIL write_access: pen=%b psel=%h done=%b, want 1 0008 000", penable, psel, done);
    end
    tick();
    n_tests++;
    if ({done, rsp_err, penable, psel, busy} !== {3'b001, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL write_done: done=%b err=%b pen=%b psel=%h busy=%b, want 001 0 0 0000 0",
               done, rsp_err, penable, psel, busy);
    end
    req = '0;
    tick();
    n_tests++;
    if (done !== 3'b000) begin
      n_fail++;
      $display("FAIL write_done_pulse: done=%b, want 000", done);
    end
  endtask

  task automatic test_read_wait();
    set_req(1, 32'h0000_1000, 1'b0, 8'h00);
    req = 3'b010; pready = 1'b0; prdata = 8'h11; pslverr = 1'b0;
    tick();  // cycle 1: SETUP
    n_tests++;
    if ({busy, penable, psel, prwd, paddr} !== {1'b1, 1'b0, 16'h0002, 1'b0, 32'h0000_1000}) begin
      n_fail++;
      $display("FAIL read_setup: busy=%b pen=%b psel=%h prwd=%b paddr=%h", busy, penable, psel, prwd, paddr);
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      n_tests++;
      if ({penable, paddr, psel, done} !== {1'b1, 32'h0000_1000, 16'h0002, 3'b000}) begin
        n_fail++;
        $display("FAIL read_wait_c%0d: pen=%b paddr=%h psel=%h done=%b", c, penable, paddr, psel, done);
      end
      if (c == 5) begin
        pready = 1'b1; prdata = 8'h5C; pslverr = 1'b1;
      end
    end
    tick();  // cycle 6
    n_tests++;
    if ({done, rsp_rdata, rsp_err} !== {3'b010, 8'h5C, 1'b1}) begin
      n_fail++;
      $display("FAIL read_done: done=%b rdata=%h err=%b, want 010 5c 1", done, rsp_rdata, rsp_err);
    end
    req = '0; pslverr = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic [AW-1:0] a [2];
    int g_exp [8];
    a[0] = 32'h0000_2000; a[1] = 32'h0000_5000;
    g_exp = '{0, 0, 1, 1, 0, 0, 1, 1};
    set_req(0, a[0], 1'b1, 8'h01);
    set_req(1, a[1], 1'b0, 8'h02);
    req = 3'b011; pready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_tests++;
      if ({busy, penable, paddr, psel} !== {1'b1, (c % 2) == 0, a[g_exp[c-1]], 16'h1 << a[g_exp[c-1]][15:12]}) begin
        n_fail++;
        $display("FAIL contention_c%0d: busy=%b pen=%b paddr=%h psel=%h, want grant %0d", c, busy, penable, paddr, psel, g_exp[c-1]);
      end
      if (c >= 3 && (c % 2) == 1) begin
        n_tests++;
        if (done !== (3'b001 << g_exp[c-3])) begin
          n_fail++;
          $display("FAIL contention_done_c%0d: done=%b, want %b", c, done, 3'b001 << g_exp[c-3]);
        end
      end
      if (c == 7) req[0] = 1'b0;
    end
    tick();  // cycle 9
    n_tests++;
    if ({done, busy, psel} !== {3'b010, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL contention_end: done=%b busy=%b psel=%h, want 010 0 0000", done, busy, psel);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(1, 32'h0000_7000, 1'b0, 8'h00);
    req = 3'b010; pready = 1'b0;
    tick(); tick(); tick();  // SETUP, ACCESS, ACCESS
    preset = 1'b0; req = '0;
    #1;
    n_tests++;
    if ({psel, penable, busy} !== {16'h0000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_abort: psel=%h pen=%b busy=%b, want 0", psel, penable, busy);
    end
    tick(); tick();
    n_tests++;
    if (done !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_done: done=%b, want 000", done);
    end
    preset = 1'b1;
    tick();
    set_req(0, 32'h0000_6010, 1'b1, 8'h33);
    set_req(1, 32'h0000_6020, 1'b1, 8'h44);
    set_req(2, 32'h0000_6030, 1'b1, 8'h55);
    req = 3'b111; pready = 1'b1;
    tick();
    n_tests++;
    if ({paddr, psel} !== {32'h0000_6010, 16'h0040}) begin
      n_fail++;
      $display("FAIL reset_mid_first_grant: paddr=%h psel=%h, want 00006010 0040", paddr, psel);
    end
    req = 3'b001;
    tick(); tick();
    n_tests++;
    if (done !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_mid_done_after: done=%b, want 001", done);
    end
    req = '0;
    tick();
  endtask

  task automatic test_timeout();
    bit ok = 1'b1;
    set_req(2, 32'h0000_F000, 1'b0, 8'h00);
    req = 3'b100; pready = 1'b0; prdata = 8'hFF; pslverr = 1'b0;
    tick();  // SETUP
`ifdef APB_ARB_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      tick();
      if (!penable || done !== 3'b000) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_wait: done or penable wrong during the 16 ACCESS cycles");
    end
    tick();
    n_tests++;
    if ({done, rsp_err, rsp_rdata} !== {3'b100, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL timeout_done: done=%b err=%b rdata=%h, want 100 1 00", done, rsp_err, rsp_rdata);
    end
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      if (!busy || done !== 3'b000) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL no_timeout_hold: busy dropped or done pulsed while pready held low");
    end
    pready = 1'b1; prdata = 8'h3C;
    tick();
    n_tests++;
    if ({done, rsp_err, rsp_rdata} !== {3'b100, 1'b0, 8'h3C}) begin
      n_fail++;
      $display("FAIL no_timeout_done: done=%b err=%b rdata=%h, want 100 0 3c", done, rsp_err, rsp_rdata);
    end
`endif
    req = '0;
    tick();
  endtask

  task automatic test_decode_sweep();
    logic [AW-1:0] a;
    for (int n = 0; n < 16; n++) begin
      a = {$urandom_range(0, 16'hFFFF), 16'h0} | (n << 12) | $urandom_range(0, 12'hFFF);
      set_req(0, a, 1'b1, 8'(n));
      req = 3'b001; pready = 1'b1;
      tick();
      n_tests++;
      if (psel !== (16'h1 << n) || !$onehot(psel)) begin
        n_fail++;
        $display("FAIL decode_%0d: psel=%h, want %h", n, psel, 16'h1 << n);
      end
      tick(); tick();
      req = '0;
      tick();
    end
  endtask

  // Transaction-level model: a transfer is granted to the first pending requester at or after
  // the pointer, spends one cycle in setup, waits for pready, and is reported the cycle after.
  task automatic test_random();
    int phase = 0, g = 0, ptr = 0, waits = 0;
    logic [N-1:0] pend, edone = '0;
    logic [AW-1:0] ma = '0;
    logic mw = 1'b0;
    logic [DW-1:0] md = '0, mr = '0;
    logic me = 1'b0, got, drain;
    preset = 1'b0; req = '0; pready = 1'b0;
    tick();
    preset = 1'b1;
    tick();
    for (int cyc = 0; cyc < 800; cyc++) begin
      drain = (cyc >= 700);
      n_tests++;
      if ({busy, penable, psel, done} !== {phase != 0, phase == 2, (phase != 0) ? 16'h1 << ma[15:12] : 16'h0, edone}) begin
        n_fail++;
        $display("FAIL rand_ctrl_c%0d: busy=%b pen=%b psel=%h done=%b, want phase %0d grant %0d done %b",
                 cyc, busy, penable, psel, done, phase, g, edone);
      end
      if (phase != 0) begin
        n_tests++;
        if ({paddr, prwd, pwdata} !== {ma, mw, md}) begin
          n_fail++;
          $display("FAIL rand_fields_c%0d: paddr=%h prwd=%b pwdata=%h, want %h %b %h", cyc, paddr, prwd, pwdata, ma, mw, md);
        end
      end
      if (edone != 0) begin
        n_tests++;
        if ({rsp_rdata, rsp_err} !== {mr, me}) begin
          n_fail++;
          $display("FAIL rand_rsp_c%0d: rdata=%h err=%b, want %h %b", cyc, rsp_rdata, rsp_err, mr, me);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (edone[i]) begin
          if (!drain && $urandom_range(0, 1) == 1) set_req(i, $urandom, 1'($urandom), 8'($urandom));
          else req[i] = 1'b0;
        end else if (!req[i] && !drain && $urandom_range(0, 3) == 0) begin
          set_req(i, $urandom, 1'($urandom), 8'($urandom));
          req[i] = 1'b1;
        end
      end
      pready  = drain || waits >= 8 || ($urandom_range(0, 1) == 1);
      prdata  = 8'($urandom);
      pslverr = 1'($urandom);
      edone = '0;
      got   = 1'b0;
      pend  = '0;
      if (phase == 2 && pready) begin
        edone[g] = 1'b1;
        if (!mw) mr = prdata;
        me    = pslverr;
        ptr   = (g + 1) % N;
        pend  = req;
        pend[g] = 1'b0;
        got   = 1'b1;
        phase = 0;
        waits = 0;
      end else if (phase == 2) begin
        waits++;
      end else if (phase == 0) begin
        pend = req;
        got  = 1'b1;
      end else begin
        phase = 2;
      end
      if (got) begin
        for (int k = 0; k < N; k++) begin
          if (pend[(ptr + k) % N]) begin
            g     = (ptr + k) % N;
            ma    = req_addr[g*AW +: AW];
            mw    = req_write[g];
            md    = req_wdata[g*DW +: DW];
            phase = 1;
            break;
          end
        end
      end
      tick();
    end
    n_tests++;
    if ({busy, req} !== '0) begin
      n_fail++;
      $display("FAIL rand_drain: busy=%b req=%b, want idle", busy, req);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_reset_mid();
    test_timeout();
    test_decode_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
